// File: rtl/aklc_keyscan.sv
// aklc_keyscan: 4x4 keypad scanner with column synchronizer, press/release
// debounce and single-cycle shift (digit) / func (non-digit) pulses.
// Optional auto-repeat while a key is held: define ACLK_KEYSCAN_AUTOREPEAT_EN.
module aklc_keyscan #(
   parameter int unsigned SCAN_DIV      = 1000,
   parameter int unsigned DEB_CYCLES    = 20000,
   parameter int unsigned REPEAT_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] key,
   output logic       shift,
   output logic       func
);

   localparam int unsigned DIV_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
   localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   // Counters below cannot represent a dwell/debounce/repeat of fewer than 2 cycles.
   if (SCAN_DIV < 2 || DEB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("aklc_keyscan: SCAN_DIV, DEB_CYCLES and REPEAT_CYCLES must be >= 2");
   end

   typedef enum logic [1:0] {SCAN, PRESS_DEB, HOLD, REL_DEB} state_t;

   state_t           state_q;
   logic [3:0]       col_m_q;
   logic [3:0]       col_s_q;
   logic [3:0]       row_q;
   logic [3:0]       lat_col_q;
   logic [3:0]       key_q;
   logic             shift_q;
   logic             func_q;
   logic [DIV_W-1:0] div_q;
   logic [DEB_W-1:0] deb_q;
   logic [3:0]       key_d;
   logic [1:0]       ridx;
   logic [1:0]       cidx;

`ifdef ACLK_KEYSCAN_AUTOREPEAT_EN
   localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0] rep_q;
`endif

   assign row   = row_q;
   assign key   = key_q;
   assign shift = shift_q;
   assign func  = func_q;

   // Map the frozen row and latched column to the key code.
   always_comb begin
      ridx = 2'd0;
      cidx = 2'd0;
      case (row_q)
         4'b0010: ridx = 2'd1;
         4'b0100: ridx = 2'd2;
         4'b1000: ridx = 2'd3;
         default: ridx = 2'd0;
      endcase
      case (lat_col_q)
         4'b0010: cidx = 2'd1;
         4'b0100: cidx = 2'd2;
         4'b1000: cidx = 2'd3;
         default: cidx = 2'd0;
      endcase
      case ({ridx, cidx})
         4'h0: key_d = 4'd1;
         4'h1: key_d = 4'd2;
         4'h2: key_d = 4'd3;
         4'h3: key_d = 4'd10;
         4'h4: key_d = 4'd4;
         4'h5: key_d = 4'd5;
         4'h6: key_d = 4'd6;
         4'h7: key_d = 4'd11;
         4'h8: key_d = 4'd7;
         4'h9: key_d = 4'd8;
         4'hA: key_d = 4'd9;
         4'hB: key_d = 4'd12;
         4'hC: key_d = 4'd14;
         4'hD: key_d = 4'd0;
         4'hE: key_d = 4'd15;
         default: key_d = 4'd13;
      endcase
   end

   // Two-flop synchronizer for the asynchronous column inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_m_q <= '0;
         col_s_q <= '0;
      end else begin
         col_m_q <= col;
         col_s_q <= col_m_q;
      end
   end

   // Scan / debounce / hold state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SCAN;
         row_q     <= 4'b0001;
         lat_col_q <= '0;
         key_q     <= '0;
         shift_q   <= 1'b0;
         func_q    <= 1'b0;
         div_q     <= '0;
         deb_q     <= '0;
`ifdef ACLK_KEYSCAN_AUTOREPEAT_EN
         rep_q     <= '0;
`endif
      end else begin
         shift_q <= 1'b0;
         func_q  <= 1'b0;
         unique case (state_q)
            SCAN: begin
               if (div_q == DIV_LAST) begin
                  div_q <= '0;
                  if ($onehot(col_s_q)) begin
                     lat_col_q <= col_s_q;
                     deb_q     <= '0;
                     state_q   <= PRESS_DEB;
                  end else begin
                     row_q <= {row_q[2:0], row_q[3]};
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            PRESS_DEB: begin
               if (col_s_q == lat_col_q) begin
                  if (deb_q == DEB_LAST) begin
                     key_q   <= key_d;
                     shift_q <= (key_d <= 4'd9);
                     func_q  <= (key_d >  4'd9);
                     state_q <= HOLD;
`ifdef ACLK_KEYSCAN_AUTOREPEAT_EN
                     rep_q   <= '0;
`endif
                  end else begin
                     deb_q <= deb_q + 1'b1;
                  end
               end else begin
                  row_q   <= {row_q[2:0], row_q[3]};
                  state_q <= SCAN;
               end
            end
            HOLD: begin
               if (col_s_q == '0) begin
                  deb_q   <= '0;
                  state_q <= REL_DEB;
`ifdef ACLK_KEYSCAN_AUTOREPEAT_EN
                  rep_q   <= '0;
               end else if (rep_q == REP_LAST) begin
                  rep_q   <= '0;
                  shift_q <= (key_q <= 4'd9);
                  func_q  <= (key_q >  4'd9);
               end else begin
                  rep_q <= rep_q + 1'b1;
`endif
               end
            end
            REL_DEB: begin
               if (col_s_q != '0) begin
                  state_q <= HOLD;
               end else if (deb_q == DEB_LAST) begin
                  row_q   <= {row_q[2:0], row_q[3]};
                  state_q <= SCAN;
               end else begin
                  deb_q <= deb_q + 1'b1;
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

endmodule

// File: tb/tb_aklc_keyscan.sv
// Scoreboard bench for aklc_keyscan with a keypad model driving col from row.
module tb_aklc_keyscan;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 8;
   localparam int REP      = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key;
   logic       shift;
   logic       func;

   logic [15:0] pressed;
   logic        contact;
   logic        bounce_active;

   typedef struct {
      bit         is_func;
      logic [3:0] code;
      int         gap;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   pulse_count = 0;
   int   last_pulse_cyc = 0;
   bit   prev_pulse = 0;
   int   model_key = 0;
   int   kmap[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

   aklc_keyscan #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
      .clk   (clk),
      .reset (reset),
      .row   (row),
      .col   (col),
      .key   (key),
      .shift (shift),
      .func  (func)
   );

   always #5 clk = ~clk;

   // Keypad: a pressed switch connects its row line to its column line.
   always_comb begin
      col = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && row[r] && contact) col[c] = 1'b1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) chk("row_onehot", int'($onehot(row)), 1);
         if (shift || func) begin
            pulse_count++;
            chk("pulse_exclusive", int'(shift && func), 0);
            chk("pulse_not_consecutive", int'(prev_pulse), 0);
            if (bounce_active) chk("pulse_during_bounce", 1, 0);
            if (sbq.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("pulse_is_func", int'(func), int'(e.is_func));
               chk("pulse_key", int'(key), int'(e.code));
               if (e.gap != 0) chk("repeat_gap", cyc - last_pulse_cyc, e.gap);
            end
            last_pulse_cyc = cyc;
         end
         prev_pulse = shift || func;
      end
   endtask

   // Press the key(s) in new_pressed, expect code of (r,c), hold k cycles past
   // the first pulse, release and confirm the scan resumes at the next row.
   task automatic run_press(input int r, input int c, input int k, input logic [15:0] new_pressed);
      int   code = kmap[r][c];
      int   n = 1;
      int   base;
      bit   seen = 0;
      exp_t e;
      logic [3:0] frozen;
      logic [3:0] nxt;
`ifdef ACLK_KEYSCAN_AUTOREPEAT_EN
      n = 1 + (k + 2) / REP;
`endif
      for (int i = 0; i < n; i++) begin
         e.is_func = (code > 9);
         e.code    = 4'(code);
         e.gap     = (i == 0) ? 0 : REP;
         sbq.push_back(e);
      end
      base = pulse_count;
      pressed = new_pressed;
      for (int t = 0; t < 400 && !seen; t++) begin
         @(negedge clk); #1;
         if (pulse_count != base) seen = 1;
      end
      if (!seen) begin
         chk("accept_timeout", 0, 1);
         sbq.delete();
      end
      model_key = code;
      repeat (k) @(posedge clk);
      #1 pressed = '0;
      frozen = 4'b0001 << r;
      nxt    = 4'b0001 << ((r + 1) % 4);
      seen = 0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk); #1;
         if (row != frozen) seen = 1;
      end
      chk("resume_row", int'(row), int'(nxt));
      chk("key_held", int'(key), model_key);
      chk("sb_drain", sbq.size(), 0);
   endtask

   task automatic wait_row(input logic [3:0] target);
      bit seen = 0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(negedge clk); #1;
         if (row == target) seen = 1;
      end
      if (!seen) chk("wait_row_timeout", int'(row), int'(target));
   endtask

   initial begin
      int r, c, k;
      reset = 1'b1;
      pressed = '0;
      contact = 1'b1;
      bounce_active = 1'b0;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_row", int'(row), 1);
      chk("reset_key", int'(key), 0);
      chk("reset_shift", int'(shift), 0);
      chk("reset_func", int'(func), 0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (10) @(posedge clk);

      // "5" clean, then "#".
      run_press(1, 1, 5, 16'h0001 << 5);
      repeat (7) @(posedge clk);
      run_press(3, 2, 5, 16'h0001 << 14);

      // Two keys on r0 together: rejected, key unchanged; then release c1.
      #1 pressed = 16'h0003;
      repeat (60) @(posedge clk);
      @(negedge clk);
      chk("multikey_key", int'(key), model_key);
      run_press(0, 0, 5, 16'h0001);

      // "7" bouncing every 3 cycles for 30 cycles, then stable.
      @(posedge clk); #1;
      bounce_active = 1'b1;
      pressed = 16'h0001 << 8;
      for (int i = 0; i < 10; i++) begin
         contact = ~contact;
         repeat (3) @(posedge clk);
         #1;
      end
      bounce_active = 1'b0;
      contact = 1'b1;
      run_press(2, 0, 5, 16'h0001 << 8);

      // Reset during the press debounce of "9".
      wait_row(4'b0010);
      pressed = 16'h0001 << 10;
      wait_row(4'b0100);
      repeat (6) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midreset_row", int'(row), 1);
      chk("midreset_key", int'(key), 0);
      chk("midreset_shift", int'(shift), 0);
      chk("midreset_func", int'(func), 0);
      @(posedge clk); #1 reset = 1'b0;
      model_key = 0;
      @(negedge clk);
      chk("postreset_pulse", int'(shift || func), 0);
      chk("postreset_key", int'(key), 0);
      run_press(2, 2, 5, 16'h0001 << 10);

      // Long hold of "3": one pulse, or four with auto-repeat.
      run_press(0, 2, 70, 16'h0001 << 2);

      // Randomised single-key presses.
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 15)) @(posedge clk);
         #1;
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         do k = $urandom_range(0, 75); while (((k + 2) % REP) == 0 || ((k + 2) % REP) == REP - 1);
         run_press(r, c, k, 16'h0001 << (r * 4 + c));
      end

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
